uart_tx_fifo: RTL and testbench

Memory-mapped UART transmitter slave with a byte FIFO, sitting directly downstream of the core's memory map on the slave data/address bus. Core stores to TXDATA push bytes into the FIFO. An independent framing FSM drains the FIFO onto `tx` at a fixed baud rate. The STATUS register gives software polling and an overflow indication.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter with a byte FIFO drained by a framing FSM.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1). Without it, frames are 8N1.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_next;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
`ifdef UART_TX_PARITY_EN
  logic               parity_bit;
`endif

  logic [1:0] offset;
  logic       push_req, push_ok, pop, clr_ovf, full, empty, baud_last;
  logic [DATA_WIDTH-1:0] status;
  logic       unused_bits;

  assign offset    = address[3:2];
  assign push_req  = we && (offset == 2'd0);
  assign clr_ovf   = we && (offset == 2'd1) && wd[3];
  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign pop       = (state == IDLE) && !empty;
  // A full FIFO still accepts a byte when the FSM frees a slot on the same edge.
  assign push_ok   = push_req && (!full || pop);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign unused_bits = ^{address[31:4], address[1:0], wd[DATA_WIDTH-1:8]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    tx         = 1'b1;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: begin
        tx = 1'b0;
        if (baud_last) state_next = DATA;
      end
      DATA: begin
        tx = shift[0];
`ifdef UART_TX_PARITY_EN
        if (baud_last && bit_cnt == 3'd7) state_next = PARITY;
      end
      PARITY: begin
        tx = parity_bit;
        if (baud_last) state_next = STOP;
`else
        if (baud_last && bit_cnt == 3'd7) state_next = STOP;
`endif
      end
      STOP:    if (baud_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (pop) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^mem[rd_ptr];
`endif
    end else if (state != IDLE) begin
      if (baud_last) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= wd[7:0];
  end

  always_comb begin
    status            = '0;
    status[0]         = full;
    status[1]         = empty;
    status[2]         = (state != IDLE);
    status[3]         = overflow;
    status[8 +: CNT_W] = count;
    rd                = '0;
    if (re && offset == 2'd1) rd = status;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of written bytes checked by a serial frame monitor.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = 11 * CPB;
`else
  localparam int FRAME_CYC = 10 * CPB;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] wd, address, rd;
  logic        we, re, tx;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0] sb [$];
  int         starts [$];
  bit         mon_busy = 1'b0;
  logic       last_parity = 1'b0;
  logic       samp [FRAME_CYC];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .wd(wd), .address(address),
    .we(we), .re(re), .rd(rd), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Serial monitor: captures one full frame per start bit and compares it with the scoreboard head.
  initial begin : monitor
    logic [7:0] exp_b, got;
    logic       exp_valid, aborted, lvl;
    int         bad, slot;
    forever begin
      @(negedge clk);
      if (!i_rst && tx === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cycle);
        exp_valid = (sb.size() > 0);
        exp_b     = exp_valid ? sb.pop_front() : 8'h00;
        aborted   = 1'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
          if (c > 0) @(negedge clk);
          if (i_rst) begin
            aborted = 1'b1;
            break;
          end
          samp[c] = tx;
        end
        if (!aborted) begin
          checks++;
          if (!exp_valid) begin
            errors++;
            $display("FAIL unexpected_frame: frame started at cycle %0d with empty scoreboard", starts[$]);
          end else begin
            bad = 0;
            for (int c = 0; c < FRAME_CYC; c++) begin
              slot = c / CPB;
              if (slot == 0)      lvl = 1'b0;
              else if (slot <= 8) lvl = exp_b[slot-1];
`ifdef UART_TX_PARITY_EN
              else if (slot == 9) lvl = ^exp_b;
`endif
              else                lvl = 1'b1;
              if (samp[c] !== lvl) bad++;
            end
            for (int b = 0; b < 8; b++) got[b] = samp[(1 + b) * CPB + CPB / 2];
`ifdef UART_TX_PARITY_EN
            last_parity = samp[9 * CPB + CPB / 2];
`endif
            if (bad != 0 || got !== exp_b) begin
              errors++;
              $display("FAIL frame: got byte %02h with %0d bad samples, expected byte %02h", got, bad, exp_b);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; wd = d; we = 1'b1; re = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b1; address = 32'h4; wd = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || mon_busy || rd[2] !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: not idle after %0d cycles, %0d bytes pending", name, n, sb.size());
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; we = 1'b0; re = 1'b1; address = 32'h4; wd = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    end
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %08h expected 00000002", rd); end
    address = 32'h0; #1;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL read_txdata: got %08h expected 0", rd); end
    address = 32'h8; #1;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL read_reserved: got %08h expected 0", rd); end
    address = 32'h4; re = 1'b0; #1;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL read_no_re: got %08h expected 0", rd); end
    re = 1'b1;
  endtask

  task automatic send_and_time(input logic [7:0] b, input string name);
    int e0, len, n;
    starts.delete();
    bus_write(32'h0, {24'hDEADBE, b});
    e0 = cycle;
    sb.push_back(b);
    @(negedge clk);
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL %s_count: got %08h expected 00000100", name, rd); end
    len = 0; n = 0;
    @(negedge clk);
    while (rd[2] === 1'b1 && n < 200) begin
      len++; n++;
      @(negedge clk);
    end
    checks++;
    if (len != FRAME_CYC) begin errors++; $display("FAIL %s_busy_len: got %0d expected %0d", name, len, FRAME_CYC); end
    wait_drain(name);
    checks++;
    if (starts.size() < 1 || starts[0] != e0 + 1) begin
      errors++;
      $display("FAIL %s_start: %0d starts, first at %0d expected %0d", name, starts.size(),
               (starts.size() > 0) ? starts[0] : -1, e0 + 1);
    end
  endtask

  task automatic test_single;
    send_and_time(8'hA5, "single");
  endtask

  task automatic test_overflow;
    bus_write(32'h0, 32'hFFFF_FF11);
    sb.push_back(8'h11);
    for (int i = 1; i <= 5; i++) begin
      bus_write(32'h0, 32'h20 + i);
      if (i <= 4) sb.push_back(8'(8'h20 + i));
    end
    @(negedge clk);
    checks++;
    if (rd !== 32'h0000_040D) begin errors++; $display("FAIL ovf_status: got %08h expected 0000040d", rd); end
    bus_write(32'h4, 32'h8);
    @(negedge clk);
    checks++;
    if (rd !== 32'h0000_0405) begin errors++; $display("FAIL ovf_clear: got %08h expected 00000405", rd); end
    wait_drain("overflow");
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL ovf_final: got %08h expected 00000002", rd); end
  endtask

  task automatic test_back_to_back;
    int n;
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      n = 0;
      @(negedge clk);
      while (rd[0] !== 1'b0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      bus_write(32'h0, 32'(i));
      sb.push_back(8'(i));
    end
    wait_drain("b2b");
    checks++;
    if (starts.size() != 10) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames expected 10", starts.size());
    end
    for (int i = 1; i < 10 && i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] != FRAME_CYC + 1) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %0d cycles expected %0d", i, starts[i] - starts[i-1], FRAME_CYC + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int lows = 0;
    bus_write(32'h0, 32'h3C); sb.push_back(8'h3C);
    bus_write(32'h0, 32'h5A); sb.push_back(8'h5A);
    bus_write(32'h0, 32'h6B); sb.push_back(8'h6B);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL midrst_status: got %08h expected 00000002", rd); end
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL midrst_quiet: tx low for %0d cycles expected 0", lows); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    send_and_time(8'h07, "parity07");
    checks++;
    if (last_parity !== 1'b1) begin errors++; $display("FAIL parity07_bit: got %b expected 1", last_parity); end
    send_and_time(8'h03, "parity03");
    checks++;
    if (last_parity !== 1'b0) begin errors++; $display("FAIL parity03_bit: got %b expected 0", last_parity); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
